// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DROP      = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, instr} pairs; flush wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic         head_valid,
    output fetch_entry_t head_entry,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one outstanding memory request feeding a 2-entry decode queue.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [1:0]      fifo_count;
    logic            fifo_valid;
    logic            outstanding;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign outstanding = (state_q != IDLE);

    // Gating on the reset pin keeps the request low while reset is held.
    assign imem_req  = reset && (state_q == IDLE) &&
                       ((fifo_count + {1'b0, outstanding}) < 2'd2);
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    assign push       = (state_q == WAIT_RESP) && imem_rvalid && !redirect_valid;
    assign pop        = fifo_valid && inst_ready && !redirect_valid;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    // A granted request racing a redirect still owes a response to drop.
                    state_d    = redirect_valid ? DROP : WAIT_RESP;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
            end
            WAIT_RESP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign inst_valid = fifo_valid;
    assign inst_data  = head_entry.instr;
    assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a memory responder plus an in-order instruction-stream model.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    int checks = 0;
    int fails  = 0;

    // Memory responder state
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    // Stream model: next address to be granted and next pc decode should receive
    logic [31:0] exp_issue = RST_PC;
    logic [31:0] exp_pc = RST_PC;

    // Per-cycle observations
    logic        s_req, s_valid, s_issue, s_pop, s_outst;
    logic [31:0] s_addr, s_pc, s_data, e_issue, e_pc;

    fetch_controller #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9617;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic gi, input logic ri, input logic rd, input logic [31:0] rp);
        imem_gnt = gi;
        inst_ready = ri;
        redirect_valid = rd;
        redirect_pc = rp;
        if (mem_pending && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_pc    = inst_pc;
        s_data  = inst_data;
        s_outst = mem_pending;
        s_issue = imem_req && gi && !rd;
        s_pop   = inst_valid && ri && !rd;
        e_issue = exp_issue;
        e_pc    = exp_pc;
        if (rd) begin
            exp_issue = {rp[31:2], 2'b00};
            exp_pc    = {rp[31:2], 2'b00};
        end else begin
            if (s_issue) exp_issue = exp_issue + 32'd4;
            if (s_pop) exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        if (imem_rvalid) mem_pending = 1'b0;
        else if (mem_pending) mem_wait--;
        if (s_req && gi) begin
            mem_pending = 1'b1;
            mem_addr    = s_addr;
            mem_wait    = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
        checks++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", inst_data); end
        checks++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== RST_PC) begin fails++; $display("FAIL first_addr: got %h want %h", imem_addr, RST_PC); end
    endtask

    task automatic test_stream();
        int pops = 0;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_issue) begin
                checks++; if (s_addr !== e_issue) begin fails++; $display("FAIL stream_addr: got %h want %h", s_addr, e_issue); end
            end
            if (s_pop) begin
                pops++;
                checks++; if (s_pc !== e_pc || s_data !== instr_of(e_pc)) begin
                    fails++; $display("FAIL stream_pop: got pc %h data %h want pc %h data %h", s_pc, s_data, e_pc, instr_of(e_pc));
                end
            end
        end
        checks++; if (pops < 10) begin fails++; $display("FAIL stream_rate: got %0d pops want >= 10", pops); end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        logic [31:0] hold_pc, hold_data;
        logic held = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (held) begin
                checks++; if (s_valid !== 1'b1 || s_pc !== hold_pc || s_data !== hold_data) begin
                    fails++; $display("FAIL hold_stable: got pc %h data %h want pc %h data %h", s_pc, s_data, hold_pc, hold_data);
                end
            end
            held = s_valid; hold_pc = s_pc; hold_data = s_data;
        end
        checks++; if (s_req !== 1'b0) begin fails++; $display("FAIL full_req: got %b want 0", s_req); end
        checks++; if (s_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %b want 1", s_valid); end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            if (s_pop) begin
                pops++;
                checks++; if (s_pc !== e_pc || s_data !== instr_of(e_pc)) begin
                    fails++; $display("FAIL drain_order: got pc %h data %h want pc %h data %h", s_pc, s_data, e_pc, instr_of(e_pc));
                end
            end
        end
        checks++; if (pops != 2) begin fails++; $display("FAIL drain_count: got %0d want 2", pops); end
    endtask

    task automatic test_gnt_stall();
        logic [31:0] first;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        first = s_addr;
        checks++; if (s_req !== 1'b1 || first !== e_issue) begin
            fails++; $display("FAIL stall_start: got req %b addr %h want req 1 addr %h", s_req, first, e_issue);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            checks++; if (s_req !== 1'b1 || s_addr !== first) begin
                fails++; $display("FAIL stall_hold: got req %b addr %h want req 1 addr %h", s_req, s_addr, first);
            end
        end
    endtask

    task automatic wait_grant(input string name);
        logic got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            got = s_issue;
        end
        checks++; if (!got) begin fails++; $display("FAIL %s_grant_timeout: got none want grant", name); end
    endtask

    task automatic test_redirect();
        logic got = 1'b0;
        logic popped = 1'b0;
        lat_min = 3; lat_max = 3;
        wait_grant("redir");
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL redir_valid: got %b want 0", s_valid); end
        for (int i = 0; i < 10 && !got; i++) begin
            if (i > 0) step(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_req) begin
                got = 1'b1;
                checks++; if (s_addr !== 32'h0000_0100) begin fails++; $display("FAIL redir_addr: got %h want 00000100", s_addr); end
            end
        end
        checks++; if (!got) begin fails++; $display("FAIL redir_req_timeout: got none want req"); end
        for (int i = 0; i < 20 && !popped; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            popped = s_pop;
        end
        checks++; if (!popped || s_pc !== 32'h0000_0100 || s_data !== instr_of(32'h0000_0100)) begin
            fails++; $display("FAIL redir_first_pop: got pc %h data %h want pc 00000100 data %h", s_pc, s_data, instr_of(32'h100));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] grants [2];
        int n = 0;
        lat_min = 1; lat_max = 1;
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 16 && n < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (s_issue) begin grants[n] = s_addr; n++; end
        end
        checks++; if (n != 2 || grants[0] !== 32'hFFFF_FFFC || grants[1] !== 32'h0) begin
            fails++; $display("FAIL wrap_addr: got %0d grants %h %h want FFFFFFFC 00000000", n, grants[0], grants[1]);
        end
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3;
        wait_grant("rstmid");
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            fails++; $display("FAIL rstmid_req: got req %b addr %h want 0 %h", imem_req, imem_addr, RST_PC);
        end
        checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            fails++; $display("FAIL rstmid_out: got valid %b data %h pc %h want 0 0 0", inst_valid, inst_data, inst_pc);
        end
        imem_rvalid = 1'b1; imem_rdata = instr_of(mem_addr);
        @(posedge clk); @(negedge clk);
        #1;
        checks++; if (inst_valid !== 1'b0 || inst_data !== 32'h0) begin
            fails++; $display("FAIL rstmid_late: got valid %b data %h want 0 0", inst_valid, inst_data);
        end
        reset = 1'b1;
        exp_issue = RST_PC; exp_pc = RST_PC;
        mem_pending = 1'b1; mem_wait = 0;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (s_req !== 1'b1 || s_addr !== RST_PC) begin
            fails++; $display("FAIL rstmid_restart: got req %b addr %h want 1 %h", s_req, s_addr, RST_PC);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL rstmid_nopush: got %b want 0", s_valid); end
        end
    endtask

    task automatic test_random();
        logic gi, ri, rd, prev_redir = 1'b0, prev_stall = 1'b0, prev_hold = 1'b0;
        logic [31:0] rp, prev_addr = '0, prev_pc = '0, prev_data = '0;
        int pops = 0;
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            gi = ($urandom_range(99, 0) < 70);
            ri = ($urandom_range(99, 0) < 60);
            rd = ($urandom_range(99, 0) < 4);
            rp = $urandom;
            step(gi, ri, rd, rp);
            if (s_outst) begin
                checks++; if (s_req !== 1'b0) begin fails++; $display("FAIL rnd_one_outstanding: got req %b want 0", s_req); end
            end
            if (prev_stall && s_req) begin
                checks++; if (s_addr !== prev_addr) begin fails++; $display("FAIL rnd_addr_stable: got %h want %h", s_addr, prev_addr); end
            end
            if (prev_redir) begin
                checks++; if (s_valid !== 1'b0) begin fails++; $display("FAIL rnd_redir_valid: got %b want 0", s_valid); end
            end
            if (prev_hold) begin
                checks++; if (s_valid !== 1'b1 || s_pc !== prev_pc || s_data !== prev_data) begin
                    fails++; $display("FAIL rnd_hold: got valid %b pc %h data %h want 1 %h %h", s_valid, s_pc, s_data, prev_pc, prev_data);
                end
            end
            if (s_issue) begin
                checks++; if (s_addr !== e_issue) begin fails++; $display("FAIL rnd_issue_addr: got %h want %h", s_addr, e_issue); end
            end
            if (s_pop) begin
                pops++;
                checks++; if (s_pc !== e_pc || s_data !== instr_of(e_pc)) begin
                    fails++; $display("FAIL rnd_pop: got pc %h data %h want pc %h data %h", s_pc, s_data, e_pc, instr_of(e_pc));
                end
            end
            prev_redir = rd;
            prev_stall = s_req && !gi && !rd;
            prev_addr  = s_addr;
            prev_hold  = s_valid && !ri && !rd;
            prev_pc    = s_pc;
            prev_data  = s_data;
        end
        checks++; if (pops < 30) begin fails++; $display("FAIL rnd_progress: got %0d pops want >= 30", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
